// File: rtl/branch_resolve_bht.sv
// branch_resolve_bht: D-stage branch resolution with a 2-bit saturating-counter BHT.
//
// Purpose:
//   Evaluates the branch condition between two forwarded operands and raises a
//   misprediction flush when the outcome differs from the prediction that came
//   down the pipe. A BHT of 2-bit counters, indexed by PC, supplies a
//   zero-latency prediction to the F stage. When the D stage is not stalled,
//   each resolved branch trains the counter at idx(res_pc).
//
// Parameters:
//   WIDTH      operand width (>= 2)
//   BHT_DEPTH  number of BHT entries, power of 2 in 2..256
//   IDX_LO     lowest PC bit used for the BHT index
//
// Ports:
//   clk, reset       rising-edge clock; asynchronous active-high reset
//   lookup_pc        F-stage PC            -> predict_taken (combinational)
//   res_valid        D-stage instruction valid
//   res_pc           PC of the branch being resolved
//   num1, num2       forwarded rs / rt operands
//   comparesel       condition select (1..10 are branches; others are not)
//   res_pred_taken   prediction originally made for this branch
//   stall            D stage frozen; blocks BHT and statistics updates
//   res_taken        resolved outcome (combinational)
//   mispredict       flush request (combinational)
//   branch_cnt       resolved-branch count (BHT_STATS_EN only, else 0)
//   mispred_cnt      misprediction count   (BHT_STATS_EN only, else 0)
//
// Build option:
//   BHT_STATS_EN  when defined, builds the branch and misprediction counters.

module branch_resolve_bht #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned BHT_DEPTH = 64,
  parameter int unsigned IDX_LO    = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      lookup_pc,
  output logic             predict_taken,
  input  logic             res_valid,
  input  logic [31:0]      res_pc,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [3:0]       comparesel,
  input  logic             res_pred_taken,
  input  logic             stall,
  output logic             res_taken,
  output logic             mispredict,
  output logic [31:0]      branch_cnt,
  output logic [31:0]      mispred_cnt
);

  localparam int unsigned IW = $clog2(BHT_DEPTH);

  logic [IW-1:0] lookup_idx;
  logic [IW-1:0] res_idx;
  logic          cond;
  logic          is_br;
  logic          upd;
  logic [1:0]    bht [BHT_DEPTH];
  logic [1:0]    cur_ctr;
  logic [1:0]    nxt_ctr;

  // PC bits outside the index window are intentionally ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, res_pc};

  assign lookup_idx = lookup_pc[IDX_LO +: IW];
  assign res_idx    = res_pc[IDX_LO +: IW];

  always_comb begin
    cond = 1'b0;
    case (comparesel)
      4'd1:    cond = (num1 == num2);
      4'd2:    cond = (num1 != num2);
      4'd3:    cond = (num1 == '0) || num1[WIDTH-1];
      4'd4:    cond = !num1[WIDTH-1] && (num1 != '0);
      4'd5:    cond = num1[WIDTH-1];
      4'd6:    cond = !num1[WIDTH-1];
      4'd7:    cond = ($signed(num1) <  $signed(num2));
      4'd8:    cond = ($signed(num1) >= $signed(num2));
      4'd9:    cond = (num1 <  num2);
      4'd10:   cond = (num1 >= num2);
      default: cond = 1'b0;
    endcase
  end

  assign is_br      = res_valid && (comparesel >= 4'd1) && (comparesel <= 4'd10);
  assign res_taken  = is_br && cond;
  assign mispredict = is_br && (res_taken != res_pred_taken);
  assign upd        = is_br && !stall;

  // Prediction reads the stored counter directly; an update in the same cycle
  // becomes visible only after the edge.
  assign predict_taken = bht[lookup_idx][1];

  assign cur_ctr = bht[res_idx];

  always_comb begin
    nxt_ctr = cur_ctr;
    if (res_taken) begin
      if (cur_ctr != 2'b11) nxt_ctr = cur_ctr + 2'd1;
    end else begin
      if (cur_ctr != 2'b00) nxt_ctr = cur_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (upd) begin
      bht[res_idx] <= nxt_ctr;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] branch_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else if (upd) begin
      branch_cnt_q <= branch_cnt_q + 32'd1;
      if (mispredict) mispred_cnt_q <= mispred_cnt_q + 32'd1;
    end
  end

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;
`else
  assign branch_cnt  = 32'd0;
  assign mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
module tb_branch_resolve_bht;

  logic        clk;
  logic        reset;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [3:0]  comparesel;
  logic        res_pred_taken;
  logic        stall;
  logic        res_taken;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int checks;
  int failures;

  branch_resolve_bht #(
    .WIDTH    (32),
    .BHT_DEPTH(64),
    .IDX_LO   (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .lookup_pc     (lookup_pc),
    .predict_taken (predict_taken),
    .res_valid     (res_valid),
    .res_pc        (res_pc),
    .num1          (num1),
    .num2          (num2),
    .comparesel    (comparesel),
    .res_pred_taken(res_pred_taken),
    .stall         (stall),
    .res_taken     (res_taken),
    .mispredict    (mispredict),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one branch at the negedge and let it cross one rising edge.
  task automatic do_branch(input logic [31:0] pc, input logic taken, input logic pred,
                           input logic st);
    @(negedge clk);
    res_valid      = 1'b1;
    res_pc         = pc;
    comparesel     = 4'd1;
    num1           = 32'd7;
    num2           = taken ? 32'd7 : 32'd8;
    res_pred_taken = pred;
    stall          = st;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    stall     = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    lookup_pc = 32'h0000_3000;
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      $display("FAIL reset_pred got=%0b exp=0", predict_taken);
      failures++;
    end
    for (int i = 0; i < 64; i += 9) begin
      checks++;
      if (dut.bht[i] !== 2'b01) begin
        $display("FAIL reset_bht[%0d] got=%b exp=01", i, dut.bht[i]);
        failures++;
      end
    end
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt);
      failures++;
    end
  endtask

  task automatic test_conditions;
    logic [3:0]  sel_v [12];
    logic [31:0] n1_v  [12];
    logic [31:0] n2_v  [12];
    logic        exp_v [12];
    sel_v = '{4'd7, 4'd9, 4'd5, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd6, 4'd8, 4'd10, 4'd12};
    n1_v  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h1234_5678, 32'h1234_5678, 32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000,
              32'h5};
    n2_v  = '{32'h1, 32'h1, 32'h1, 32'h1, 32'h1, 32'h1234_5678, 32'h1234_5678, 32'h0,
              32'h0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h5};
    exp_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    // Stall held so the sweep leaves the BHT untouched.
    @(negedge clk);
    stall          = 1'b1;
    res_valid      = 1'b1;
    res_pred_taken = 1'b1;
    for (int i = 0; i < 12; i++) begin
      comparesel = sel_v[i];
      num1       = n1_v[i];
      num2       = n2_v[i];
      #1;
      checks++;
      if (res_taken !== exp_v[i]) begin
        $display("FAIL cond_sel%0d got=%0b exp=%0b", sel_v[i], res_taken, exp_v[i]);
        failures++;
      end
      checks++;
      if (mispredict !== (sel_v[i] inside {[4'd1:4'd10]} && !exp_v[i])) begin
        $display("FAIL mispred_sel%0d got=%0b exp=%0b", sel_v[i], mispredict,
                 sel_v[i] inside {[4'd1:4'd10]} && !exp_v[i]);
        failures++;
      end
    end
    res_valid  = 1'b0;
    comparesel = 4'd1;
    num1       = 32'd3;
    num2       = 32'd3;
    #1;
    checks++;
    if (res_taken !== 1'b0 || mispredict !== 1'b0) begin
      $display("FAIL invalid_slot got=%0b/%0b exp=0/0", res_taken, mispredict);
      failures++;
    end
    stall = 1'b0;
  endtask

  task automatic test_saturation;
    lookup_pc = 32'h0000_3010;
    for (int i = 0; i < 4; i++) do_branch(32'h3010, 1'b1, 1'b0, 1'b0);
    checks++;
    if (dut.bht[4] !== 2'b11) begin
      $display("FAIL sat_high got=%b exp=11", dut.bht[4]);
      failures++;
    end
    do_branch(32'h3010, 1'b0, 1'b1, 1'b0);
    checks++;
    if (predict_taken !== 1'b1) begin
      $display("FAIL sat_one_nt got=%0b exp=1", predict_taken);
      failures++;
    end
    do_branch(32'h3010, 1'b0, 1'b1, 1'b0);
    checks++;
    if (predict_taken !== 1'b0) begin
      $display("FAIL sat_two_nt got=%0b exp=0", predict_taken);
      failures++;
    end
    for (int i = 0; i < 3; i++) do_branch(32'h3010, 1'b0, 1'b0, 1'b0);
    checks++;
    if (dut.bht[4] !== 2'b00) begin
      $display("FAIL sat_low got=%b exp=00", dut.bht[4]);
      failures++;
    end
  endtask

  task automatic test_aliasing;
    do_branch(32'h3004, 1'b1, 1'b0, 1'b0);
    lookup_pc = 32'h0000_3104;
    #1;
    checks++;
    if (predict_taken !== 1'b1) begin
      $display("FAIL alias_3104 got=%0b exp=1", predict_taken);
      failures++;
    end
    lookup_pc = 32'h0000_3008;
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      $display("FAIL alias_3008 got=%0b exp=0", predict_taken);
      failures++;
    end
  endtask

  task automatic test_stall_same_cycle;
    lookup_pc = 32'h0000_300C;
    for (int i = 0; i < 3; i++) do_branch(32'h300C, 1'b1, 1'b0, 1'b1);
    checks++;
    if (dut.bht[3] !== 2'b01 || predict_taken !== 1'b0) begin
      $display("FAIL stall_block got=%b/%0b exp=01/0", dut.bht[3], predict_taken);
      failures++;
    end
    @(negedge clk);
    res_valid      = 1'b1;
    res_pc         = 32'h300C;
    comparesel     = 4'd1;
    num1           = 32'd9;
    num2           = 32'd9;
    res_pred_taken = 1'b0;
    stall          = 1'b0;
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      $display("FAIL same_cycle_old got=%0b exp=0", predict_taken);
      failures++;
    end
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    checks++;
    if (predict_taken !== 1'b1) begin
      $display("FAIL same_cycle_new got=%0b exp=1", predict_taken);
      failures++;
    end
  endtask

  task automatic test_reset_midop;
    @(negedge clk);
    res_valid      = 1'b1;
    res_pc         = 32'h3014;
    comparesel     = 4'd1;
    num1           = 32'd1;
    num2           = 32'd1;
    res_pred_taken = 1'b0;
    stall          = 1'b0;
    reset          = 1'b1;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    checks++;
    if (dut.bht[5] !== 2'b01 || dut.bht[3] !== 2'b01) begin
      $display("FAIL midop_reset got=%b/%b exp=01/01", dut.bht[5], dut.bht[3]);
      failures++;
    end
    @(negedge clk);
    reset     = 1'b0;
    lookup_pc = 32'h0000_300C;
    #1;
    checks++;
    if (predict_taken !== 1'b0) begin
      $display("FAIL midop_pred got=%0b exp=0", predict_taken);
      failures++;
    end
  endtask

  task automatic test_stats;
    do_branch(32'h3020, 1'b1, 1'b1, 1'b0);
    do_branch(32'h3020, 1'b1, 1'b0, 1'b0);
    do_branch(32'h3024, 1'b0, 1'b0, 1'b0);
    do_branch(32'h3024, 1'b0, 1'b1, 1'b0);
    do_branch(32'h3028, 1'b1, 1'b1, 1'b0);
    do_branch(32'h3028, 1'b1, 1'b0, 1'b1);
`ifdef BHT_STATS_EN
    checks++;
    if (branch_cnt !== 32'd5 || mispred_cnt !== 32'd2) begin
      $display("FAIL stats_count got=%0d/%0d exp=5/2", branch_cnt, mispred_cnt);
      failures++;
    end
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    do_branch(32'h3028, 1'b1, 1'b1, 1'b0);
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd2) begin
      $display("FAIL stats_wrap got=%0d/%0d exp=0/2", branch_cnt, mispred_cnt);
      failures++;
    end
`else
    checks++;
    if (branch_cnt !== 32'd0 || mispred_cnt !== 32'd0) begin
      $display("FAIL stats_tied got=%0d/%0d exp=0/0", branch_cnt, mispred_cnt);
      failures++;
    end
`endif
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    lookup_pc      = 32'h0;
    res_valid      = 1'b0;
    res_pc         = 32'h0;
    num1           = 32'h0;
    num2           = 32'h0;
    comparesel     = 4'd0;
    res_pred_taken = 1'b0;
    stall          = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_conditions();
    test_saturation();
    test_aliasing();
    test_stall_same_cycle();
    test_reset_midop();
    test_stats();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
